// File: rtl/wb_xbar_rr_if.sv
// Wishbone classic bundle carrying N parallel ports.
// The master modport is the side that issues cycles, and the slave modport is the side that answers them.
interface wb_xbar_rr_if #(
  parameter int N         = 1,
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 32
);
  logic [N-1:0]             cyc;
  logic [N-1:0]             stb;
  logic [N-1:0]             we;
  logic [N*ADR_WIDTH-1:0]   adr;
  logic [N*DAT_WIDTH-1:0]   dat_w;
  logic [N*DAT_WIDTH/8-1:0] sel;
  logic [N*DAT_WIDTH-1:0]   dat_r;
  logic [N-1:0]             ack;
  logic [N-1:0]             err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_xbar_rr.sv
// Wishbone classic crossbar with M_COUNT masters and S_COUNT slaves.
// Each slave has its own round-robin arbiter and ack timeout.
// Addresses that no slave claims get a registered decode error.
module wb_xbar_rr #(
  parameter int                           M_COUNT   = 2,
  parameter int                           S_COUNT   = 2,
  parameter int                           DAT_WIDTH = 32,
  parameter int                           ADR_WIDTH = 32,
  parameter logic [S_COUNT*ADR_WIDTH-1:0] S_BASE    = '0,
  parameter logic [S_COUNT*ADR_WIDTH-1:0] S_MASK    = '0,
  parameter int                           TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  wb_xbar_rr_if.slave  m,
  wb_xbar_rr_if.master s
);
  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  localparam int MW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int SW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  arb_state_t         state   [S_COUNT];
  logic [MW-1:0]      owner   [S_COUNT];
  logic [MW-1:0]      ptr     [S_COUNT];
  logic [CW-1:0]      tmo_cnt [S_COUNT];
  logic [M_COUNT-1:0] dec_err_q;

  logic [M_COUNT-1:0] hit;
  logic [SW-1:0]      target  [M_COUNT];
  logic [M_COUNT-1:0] busy;
  logic [M_COUNT-1:0] req     [S_COUNT];
  logic [S_COUNT-1:0] pick_vld;
  logic [MW-1:0]      pick_idx [S_COUNT];
  logic [S_COUNT-1:0] fire;

  logic [S_COUNT-1:0]           s_cyc_c, s_stb_c, s_we_c;
  logic [S_COUNT*ADR_WIDTH-1:0] s_adr_c;
  logic [S_COUNT*DAT_WIDTH-1:0] s_dat_w_c;
  logic [S_COUNT*SEL_WIDTH-1:0] s_sel_c;
  logic [M_COUNT-1:0]           m_ack_c, m_err_c;
  logic [M_COUNT*DAT_WIDTH-1:0] m_dat_r_c;

  // Returns the master index that lies off positions after base, wrapping at M_COUNT.
  function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= M_COUNT) sum -= M_COUNT;
    return MW'(sum);
  endfunction

  // Decodes each master's address; the descending scan lets the lowest matching slave win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    hit = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      target[i] = '0;
      for (int j = S_COUNT - 1; j >= 0; j--) begin
        if ((m.adr[i*ADR_WIDTH +: ADR_WIDTH] & S_MASK[j*ADR_WIDTH +: ADR_WIDTH])
            == S_BASE[j*ADR_WIDTH +: ADR_WIDTH]) begin
          hit[i]    = 1'b1;
          target[i] = SW'(j);
        end
      end
    end
  end

  // Builds the requester set per slave and picks the first requester at or after the pointer.
  always_comb begin
    busy = '0;
    for (int j = 0; j < S_COUNT; j++)
      if (state[j] == OWNED) busy[owner[j]] = 1'b1;
    for (int j = 0; j < S_COUNT; j++) begin
      req[j]      = '0;
      pick_vld[j] = 1'b0;
      pick_idx[j] = ptr[j];
      fire[j]     = (TIMEOUT != 0) && (state[j] == OWNED) && (tmo_cnt[j] == CW'(TIMEOUT));
      // A master that already owns a slave cannot pick up a second grant.
      for (int i = 0; i < M_COUNT; i++)
        req[j][i] = m.cyc[i] & m.stb[i] & hit[i] & (target[i] == SW'(j)) & ~busy[i];
      for (int k = M_COUNT - 1; k >= 0; k--) begin
        if (req[j][rr_idx(ptr[j], k)]) begin
          pick_vld[j] = 1'b1;
          pick_idx[j] = rr_idx(ptr[j], k);
        end
      end
    end
  end

  // Drives each owned slave from its owning master; a firing timeout suppresses the strobe.
  always_comb begin
    s_cyc_c   = '0;
    s_stb_c   = '0;
    s_we_c    = '0;
    s_adr_c   = '0;
    s_dat_w_c = '0;
    s_sel_c   = '0;
    for (int j = 0; j < S_COUNT; j++) begin
      if (state[j] == OWNED) begin
        s_cyc_c[j] = m.cyc[owner[j]];
        s_stb_c[j] = m.stb[owner[j]] & ~fire[j];
        s_we_c[j]  = m.we[owner[j]];
        s_adr_c[j*ADR_WIDTH +: ADR_WIDTH]   = m.adr[int'(owner[j])*ADR_WIDTH +: ADR_WIDTH];
        s_dat_w_c[j*DAT_WIDTH +: DAT_WIDTH] = m.dat_w[int'(owner[j])*DAT_WIDTH +: DAT_WIDTH];
        s_sel_c[j*SEL_WIDTH +: SEL_WIDTH]   = m.sel[int'(owner[j])*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  // Routes slave responses back to the owning master only; a slave ack in the same cycle beats a timeout error.
  always_comb begin
    m_ack_c   = '0;
    m_err_c   = dec_err_q;
    m_dat_r_c = '0;
    for (int j = 0; j < S_COUNT; j++) begin
      if (state[j] == OWNED) begin
        m_ack_c[owner[j]] = m_ack_c[owner[j]] | s.ack[j];
        m_err_c[owner[j]] = m_err_c[owner[j]] | s.err[j] | (fire[j] & ~s.ack[j]);
        m_dat_r_c[int'(owner[j])*DAT_WIDTH +: DAT_WIDTH] = s.dat_r[j*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign s.cyc   = s_cyc_c;
  assign s.stb   = s_stb_c;
  assign s.we    = s_we_c;
  assign s.adr   = s_adr_c;
  assign s.dat_w = s_dat_w_c;
  assign s.sel   = s_sel_c;
  assign m.ack   = m_ack_c;
  assign m.err   = m_err_c;
  assign m.dat_r = m_dat_r_c;

  // Per-slave arbiter FSM, timeout counter and decode-error pulse generator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the per-slave arrays are a few flops each, not a RAM, so they clear with every other register.
      for (int j = 0; j < S_COUNT; j++) begin
        state[j]   <= IDLE;
        owner[j]   <= '0;
        ptr[j]     <= '0;
        tmo_cnt[j] <= '0;
      end
      dec_err_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      for (int j = 0; j < S_COUNT; j++) begin
        case (state[j])
          IDLE: begin
            tmo_cnt[j] <= '0;
            if (pick_vld[j]) begin
              state[j] <= OWNED;
              owner[j] <= pick_idx[j];
            end
          end
          OWNED: begin
            if (!m.cyc[owner[j]]) begin
              state[j]   <= IDLE;
              ptr[j]     <= rr_idx(owner[j], 1);
              tmo_cnt[j] <= '0;
            end else if (fire[j] || s.ack[j] || s.err[j]) begin
              tmo_cnt[j] <= '0;
            end else if (s_stb_c[j] && (TIMEOUT != 0)) begin
              tmo_cnt[j] <= tmo_cnt[j] + 1'b1;
            end
          end
          default: state[j] <= IDLE;
        endcase
      end
      // Unmapped requests pulse err every other cycle while the strobe stays high.
      dec_err_q <= m.cyc & m.stb & ~hit & ~busy & ~dec_err_q;
    end
  end
endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed bench for wb_xbar_rr: hand-computed spot checks plus a per-cycle comparison against a behavioural model.
module tb_wb_xbar_rr;
  localparam int M = 2, S = 2, DW = 32, AW = 32, SELW = 4, TO = 4;
  localparam logic [S*AW-1:0] BASE = {32'h0000_1000, 32'h0000_0000};
  localparam logic [S*AW-1:0] MASK = {32'h0000_F000, 32'h0000_F000};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_xbar_rr_if #(.N(M), .DAT_WIDTH(DW), .ADR_WIDTH(AW)) mb ();
  wb_xbar_rr_if #(.N(S), .DAT_WIDTH(DW), .ADR_WIDTH(AW)) sb ();

  wb_xbar_rr #(
    .M_COUNT(M), .S_COUNT(S), .DAT_WIDTH(DW), .ADR_WIDTH(AW),
    .S_BASE(BASE), .S_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .m     (mb.slave),
    .s     (sb.master)
  );

  // Slave side: manual ack/err, or zero-wait auto-ack on the slave's strobe.
  logic [S-1:0] man_ack = '0, man_err = '0, auto_ack = '0;
  assign sb.ack   = man_ack | (auto_ack & sb.stb);
  assign sb.err   = man_err;
  assign sb.dat_r = {32'hB1B1_0001, 32'hA0A0_0000};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int own_m  [S];   // owning master per slave, -1 when free
  int ptr_m  [S];   // next master favoured by round robin
  int cnt_m  [S];   // stalled strobe cycles seen by the owner
  int de_run [M];   // consecutive unmapped strobe cycles

  logic [S-1:0]    e_scyc, e_sstb, e_swe, e_fire, e_sack;
  logic [S*AW-1:0] e_sadr;
  logic [S*DW-1:0] e_sdatw;
  logic [S*SELW-1:0] e_ssel;
  logic [M-1:0]    e_mack, e_merr;
  logic [M*DW-1:0] e_mdatr;

  function automatic int decode(input logic [AW-1:0] a);
    logic [S*AW-1:0] b, k;
    b = BASE;
    k = MASK;
    for (int i = 0; i < S; i++)
      if ((a & k[i*AW +: AW]) == b[i*AW +: AW]) return i;
    return -1;
  endfunction

  function automatic void compute_exp();
    int o;
    e_scyc = '0; e_sstb = '0; e_swe = '0; e_fire = '0; e_sack = '0;
    e_sadr = '0; e_sdatw = '0; e_ssel = '0;
    e_mack = '0; e_merr = '0; e_mdatr = '0;
    for (int i = 0; i < S; i++) begin
      o = own_m[i];
      if (o >= 0) begin
        e_fire[i] = (cnt_m[i] == TO);
        e_scyc[i] = mb.cyc[o];
        e_sstb[i] = mb.stb[o] && !e_fire[i];
        e_swe[i]  = mb.we[o];
        e_sadr[i*AW +: AW]     = mb.adr[o*AW +: AW];
        e_sdatw[i*DW +: DW]    = mb.dat_w[o*DW +: DW];
        e_ssel[i*SELW +: SELW] = mb.sel[o*SELW +: SELW];
      end
      e_sack[i] = man_ack[i] | (auto_ack[i] & e_sstb[i]);
    end
    for (int i = 0; i < M; i++) e_merr[i] = (de_run[i] % 2) == 1;
    for (int i = 0; i < S; i++) begin
      o = own_m[i];
      if (o >= 0) begin
        e_mack[o] = e_mack[o] | e_sack[i];
        e_merr[o] = e_merr[o] | man_err[i] | (e_fire[i] & !e_sack[i]);
        e_mdatr[o*DW +: DW] = sb.dat_r[i*DW +: DW];
      end
    end
  endfunction

  // Compare on every falling edge, then advance the model to the next rising edge
  // (inputs are stable from the falling edge to the next rising edge).
  initial begin
    logic [M-1:0] busy;
    int c;
    bit found;
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int i = 0; i < S; i++) begin own_m[i] = -1; ptr_m[i] = 0; cnt_m[i] = 0; end
        for (int i = 0; i < M; i++) de_run[i] = 0;
      end
      compute_exp();
      check("s_cyc",   sb.cyc,   e_scyc);
      check("s_stb",   sb.stb,   e_sstb);
      check("s_we",    sb.we,    e_swe);
      check("s_adr",   sb.adr,   e_sadr);
      check("s_dat_w", sb.dat_w, e_sdatw);
      check("s_sel",   sb.sel,   e_ssel);
      check("m_ack",   mb.ack,   e_mack);
      check("m_err",   mb.err,   e_merr);
      check("m_dat_r", mb.dat_r, e_mdatr);
      if (!reset) begin
        busy = '0;
        for (int i = 0; i < S; i++) if (own_m[i] >= 0) busy[own_m[i]] = 1'b1;
        for (int i = 0; i < M; i++) begin
          if (mb.cyc[i] && mb.stb[i] && decode(mb.adr[i*AW +: AW]) < 0 && !busy[i]) de_run[i]++;
          else de_run[i] = 0;
        end
        for (int i = 0; i < S; i++) begin
          if (own_m[i] < 0) begin
            found = 0;
            cnt_m[i] = 0;
            for (int k = 0; k < M; k++) begin
              c = (ptr_m[i] + k) % M;
              if (!found && mb.cyc[c] && mb.stb[c] && !busy[c] && decode(mb.adr[c*AW +: AW]) == i) begin
                own_m[i] = c;
                found = 1;
              end
            end
          end else if (!mb.cyc[own_m[i]]) begin
            ptr_m[i] = (own_m[i] + 1) % M;
            own_m[i] = -1;
            cnt_m[i] = 0;
          end else if (e_fire[i] || e_sack[i] || man_err[i]) begin
            cnt_m[i] = 0;
          end else if (e_sstb[i]) begin
            cnt_m[i]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_m(input int i, input logic c, input logic st, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    mb.cyc[i] = c;
    mb.stb[i] = st;
    mb.we[i]  = w;
    mb.adr[i*AW +: AW]     = a;
    mb.dat_w[i*DW +: DW]   = d;
    mb.sel[i*SELW +: SELW] = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mb.cyc = '0; mb.stb = '0; mb.we = '0; mb.adr = '0; mb.dat_w = '0; mb.sel = '0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_s_cyc", sb.cyc, 2'b00);
    check("rst_m_ack", mb.ack, 2'b00);
    tick();
    reset = 1'b0;
    tick();

    // Single master write to slave 1, one-cycle arbitration, ack passes straight through.
    set_m(0, 1, 1, 1, 32'h0000_1004, 32'hDEAD_BEEF);
    #2 check("t1_latency", sb.stb, 2'b00);
    tick();
    #2 check("t1_stb", sb.stb, 2'b10);
    check("t1_adr", sb.adr[63:32], 32'h0000_1004);
    check("t1_dat", sb.dat_w[63:32], 32'hDEAD_BEEF);
    man_ack[1] = 1'b1;
    #1 check("t1_ack", mb.ack, 2'b01);
    tick();
    man_ack = '0;
    set_m(0, 0, 0, 0, '0, '0);
    tick();

    // Both masters on slave 0: m0 first, then m1 beats a re-requesting m0, then m0 again.
    auto_ack[0] = 1'b1;
    set_m(0, 1, 1, 0, 32'h0000_0010, '0);
    set_m(1, 1, 1, 0, 32'h0000_0020, '0);
    tick();
    #2 check("t2_own_m0", sb.adr[31:0], 32'h0000_0010);
    check("t2_ack_m0", mb.ack, 2'b01);
    check("t2_dat_m0", mb.dat_r[31:0], 32'hA0A0_0000);
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    #2 check("t2_drop", sb.cyc, 2'b00);
    tick();
    set_m(0, 1, 1, 0, 32'h0000_0010, '0);
    tick();
    #2 check("t2_rr_m1", sb.adr[31:0], 32'h0000_0020);
    check("t2_ack_m1", mb.ack, 2'b10);
    tick();
    set_m(1, 0, 0, 0, '0, '0);
    tick();
    tick();
    #2 check("t2_rr_m0", sb.adr[31:0], 32'h0000_0010);
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    tick();
    auto_ack = '0;

    // Concurrent grants on different slaves with independent acks.
    auto_ack[0] = 1'b1;
    set_m(0, 1, 1, 1, 32'h0000_0100, 32'h1111_1111);
    set_m(1, 1, 1, 1, 32'h0000_1200, 32'h2222_2222);
    tick();
    #2 check("t3_stb", sb.stb, 2'b11);
    check("t3_adr", sb.adr, {32'h0000_1200, 32'h0000_0100});
    check("t3_ack_one", mb.ack, 2'b01);
    man_ack[1] = 1'b1;
    #1 check("t3_ack_both", mb.ack, 2'b11);
    tick();
    man_ack = '0;
    auto_ack = '0;
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    tick();

    // Unmapped read: registered err pulse, repeating every other cycle, no slave strobe.
    set_m(0, 1, 1, 0, 32'h0000_8000, '0);
    #2 check("t4_err_0", mb.err, 2'b00);
    tick();
    #2 check("t4_err_1", mb.err, 2'b01);
    check("t4_no_stb", sb.stb, 2'b00);
    tick();
    #2 check("t4_err_2", mb.err, 2'b00);
    tick();
    #2 check("t4_err_3", mb.err, 2'b01);
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    #2 check("t4_err_4", mb.err, 2'b00);
    tick();

    // Timeout: four stalled cycles, then err with the strobe suppressed; second round the ack wins.
    set_m(0, 1, 1, 0, 32'h0000_0040, '0);
    tick();
    for (int k = 0; k < TO; k++) begin
      #2 check("t5_stall", {sb.stb[0], mb.err[0]}, 2'b10);
      tick();
    end
    #2 check("t5_fire_err", mb.err, 2'b01);
    check("t5_fire_stb", sb.stb, 2'b00);
    check("t5_fire_cyc", sb.cyc, 2'b01);
    tick();
    for (int k = 0; k < TO; k++) begin
      #2 check("t5_stall2", {sb.stb[0], mb.err[0]}, 2'b10);
      tick();
    end
    man_ack[0] = 1'b1;
    #2 check("t5_ack_wins", {mb.ack[0], mb.err[0]}, 2'b10);
    tick();
    man_ack = '0;
    set_m(0, 0, 0, 0, '0, '0);
    tick();

    // Reset while slave 0 is owned: strobes drop at once, no ack leaks, pointer back to m0.
    set_m(0, 1, 1, 0, 32'h0000_0080, '0);
    tick();
    #2 check("t6_owned", sb.stb, 2'b01);
    reset = 1'b1;
    man_ack[0] = 1'b1;
    #1 check("t6_rst_cyc", sb.cyc, 2'b00);
    check("t6_rst_stb", sb.stb, 2'b00);
    check("t6_rst_ack", mb.ack, 2'b00);
    man_ack = '0;
    set_m(1, 1, 1, 0, 32'h0000_0090, '0);
    tick();
    reset = 1'b0;
    #2 check("t6_latency", sb.stb, 2'b00);
    tick();
    #2 check("t6_ptr_m0", sb.adr[31:0], 32'h0000_0080);
    check("t6_stb", sb.stb, 2'b01);
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_xbar_rr.md
Name: wb_xbar_rr

Overview:
- Parametrised Wishbone classic crossbar: M_COUNT masters to S_COUNT slaves.
- Each slave has its own round-robin arbiter, so masters addressing different slaves proceed concurrently.
- Adds a per-slave base/mask address map, a decode-error response for unmapped addresses, and a per-slave ack timeout.
- Sits between the CPU, DMA and debug masters and the UART, RAM and GPIO slaves at the top level.

Parameters:
- M_COUNT, 2, number of masters (1..8).
- S_COUNT, 2, number of slaves (1..8).
- DAT_WIDTH, 32, data bus width; SEL width is DAT_WIDTH/8.
- ADR_WIDTH, 32, address width.
- S_BASE, {S_COUNT{32'h0}}, packed per-slave base addresses; slave s occupies bits [s*ADR_WIDTH +: ADR_WIDTH].
- S_MASK, {S_COUNT{32'h0}}, packed per-slave address masks, same packing as S_BASE.
- TIMEOUT, 255, cycles to wait for a slave ack before returning err; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_cyc  in  M_COUNT  master cycle.
- m_stb  in  M_COUNT  master strobe.
- m_we  in  M_COUNT  master write enable.
- m_adr  in  M_COUNT*ADR_WIDTH  master address.
- m_dat_w  in  M_COUNT*DAT_WIDTH  master write data.
- m_sel  in  M_COUNT*DAT_WIDTH/8  master byte select.
- m_dat_r  out  M_COUNT*DAT_WIDTH  read data to master.
- m_ack  out  M_COUNT  ack to master.
- m_err  out  M_COUNT  error to master.
- s_cyc, s_stb, s_we  out  S_COUNT each  slave cycle, strobe and write enable.
- s_adr  out  S_COUNT*ADR_WIDTH  slave address.
- s_dat_w  out  S_COUNT*DAT_WIDTH  slave write data.
- s_sel  out  S_COUNT*DAT_WIDTH/8  slave byte select.
- s_dat_r  in  S_COUNT*DAT_WIDTH  read data from slave.
- s_ack  in  S_COUNT  slave ack.
- s_err  in  S_COUNT  slave error.

Behaviour:
- Reset (asynchronous, immediate):
  - all grants cleared.
  - all round-robin pointers = 0.
  - timeout counters = 0.
  - s_cyc/s_stb = 0; m_ack/m_err = 0; m_dat_r = 0.
- Reset asserted mid-transfer drops every slave strobe in the same cycle. No ack may reach a master while reset is high.
- Decode (combinational):
  - master m targets slave s when (m_adr & S_MASK[s]) == S_BASE[s].
  - overlapping matches: lowest s wins.
  - no match: decode error.
- Per-slave arbiter FSM, states IDLE and OWNED:
  - IDLE: requesters are masters with cyc&stb decoding to s. Grant the first requester at or after the round-robin pointer (searching upward, wrapping M_COUNT-1 -> 0). Grant is registered, so OWNED begins next cycle. Arbitration latency is 1 cycle.
  - OWNED(m): s_* signals are driven combinationally from master m. s_ack/s_err/s_dat_r are routed only to master m. Unowned slaves see cyc=stb=0; non-granted masters see ack=err=0.
  - OWNED -> IDLE when the owning master drops m_cyc. The pointer becomes m+1 mod M_COUNT.
  - Grant is held across back-to-back strobes while cyc stays high (locked cycle). An address change to another slave while locked is a protocol violation; behaviour is unspecified.
- A master never holds more than one grant.
- Masters requesting different slaves are granted in the same cycle.
- Decode error:
  - m_err pulses for 1 cycle, registered: asserted the cycle after stb is sampled high.
  - m_err repeats every other cycle while stb stays high.
  - no slave sees the request.
- Timeout, per slave, in OWNED:
  - counter increments on each cycle with s_stb=1 and s_ack=s_err=0.
  - counter clears on ack, on err, or on leaving OWNED.
  - when the count reaches TIMEOUT: m_err pulses 1 cycle; s_stb is forced to 0 that cycle; counter clears; grant is retained until cyc drops.
  - a slave ack in the same cycle the timeout fires wins (ack passed, no err).
- An ack and an err from the slave in the same cycle are both forwarded unchanged.
- Width rule: index signals are $clog2(M_COUNT) bits, with a minimum of 1 bit.

Test Plan:
- Single master, S_BASE={0x1000,0x0}, S_MASK={0xF000,0xF000}. m0 write 0x1004 data 0xDEADBEEF. Required: slave1 stb in cycle 2 with adr 0x1004, dat 0xDEADBEEF; slave1 ack -> m0 ack in the same cycle.
- Two masters both request slave0 in cycle 0. Required: m0 granted first. After m0 drops cyc, m1 granted 1 cycle later. Both then request again: m1 wins, confirming the round-robin pointer.
- m0 targets slave0 and m1 targets slave1 simultaneously. Required: both granted in cycle 1 and both acks are independent.
- m0 read from 0x8000 (unmapped). Required: m_err[0]=1 one cycle after stb; all s_stb stay 0.
- TIMEOUT=4, slave never acks. Required: m_err pulses after 4 stalled cycles and s_stb=0 in that cycle. A second run with the ack arriving in cycle 4 passes ack with no err.
- Assert reset mid-read while slave0 is owned. Required: s_cyc/s_stb drop immediately. After release, a new request sees 1-cycle arbitration with the pointer reset to m0.
